// File: rtl/br_update_queue_pkg.sv
// Shared definitions for the branch update queue: lane count, lane-slice
// macro, entry field widths and the stored entry layout.
`ifndef SCALAR
`define SCALAR 2
`endif
`ifndef SEL
`define SEL(w, n) ((w)*(n)) +: (w)
`endif

package br_update_queue_pkg;

    localparam int unsigned LANES = `SCALAR;
    localparam int unsigned NPC_W = 64;
    localparam int unsigned TGT_W = 64;
    localparam int unsigned TKN_W = 1;

    // One resolved branch as held in the queue
    typedef struct packed {
        logic [NPC_W-1:0] npc;
        logic [TGT_W-1:0] target;
        logic [TKN_W-1:0] taken;
    } brq_entry_t;

endpackage

// File: rtl/br_update_queue_brq_ram.sv
// DEPTH-entry branch storage: two write ports (compacted lanes, distinct
// addresses) and two combinational read ports at head and head+1.
module br_update_queue_brq_ram
    import br_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             i_we0,
    input  logic [IDX_W-1:0] i_waddr0,
    input  brq_entry_t       i_wdata0,
    input  logic             i_we1,
    input  logic [IDX_W-1:0] i_waddr1,
    input  brq_entry_t       i_wdata1,
    input  logic [IDX_W-1:0] i_raddr0,
    input  logic [IDX_W-1:0] i_raddr1,
    output brq_entry_t       o_rdata0_c,
    output brq_entry_t       o_rdata1_c
);

    brq_entry_t r_mem [DEPTH];

    // Storage write; the two ports always target consecutive slots
    always_ff @(posedge clk) begin
        if (i_we0) r_mem[i_waddr0] <= i_wdata0;
        if (i_we1) r_mem[i_waddr1] <= i_wdata1;
    end

    assign o_rdata0_c = r_mem[i_raddr0];
    assign o_rdata1_c = r_mem[i_raddr1];

endmodule

// File: rtl/br_update_queue.sv
// In-order queue of resolved branches between execute and the predictor
// update port; only retired entries are presented to the predictor.
// Optional macro BRQ_PERF_EN adds retired / retired-taken counters.
module br_update_queue
    import br_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [`SCALAR-1:0]        ex_br_valid,
    input  logic [`SCALAR*NPC_W-1:0]  ex_npc,
    input  logic [`SCALAR-1:0]        ex_taken,
    input  logic [`SCALAR*TGT_W-1:0]  ex_target,
    output logic                      brq_ready,
    input  logic [1:0]                rob_retire_cnt,
    input  logic                      rob_flush,
    output logic [`SCALAR-1:0]        ROB_br_en,
    output logic [`SCALAR*NPC_W-1:0]  ROB_NPC,
    output logic [`SCALAR-1:0]        ROB_taken,
    output logic [`SCALAR*TGT_W-1:0]  ROB_taken_address,
    output logic                      brq_err
`ifdef BRQ_PERF_EN
    ,
    output logic [31:0]               perf_br_retired,
    output logic [31:0]               perf_br_taken
`endif
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [1:0]       w_req;
    logic [1:0]       w_n;
    logic             w_deq_err;
    logic [CNT_W-1:0] w_free;
    logic [1:0]       w_pop;
    logic [1:0]       w_acc;
    logic             w_enq_err;
    logic [IDX_W-1:0] w_head_next;
    logic [IDX_W-1:0] w_tail_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_v0;
    logic             w_v1;
    brq_entry_t       w_lane0;
    brq_entry_t       w_lane1;
    brq_entry_t       w_wdata0;
    brq_entry_t       w_rd0;
    brq_entry_t       w_rd1;

    // Retire/enqueue arithmetic: clamp requests to what the queue can honour
    always_comb begin
        w_req     = (rob_retire_cnt == 2'd3) ? 2'd2 : rob_retire_cnt;
        w_deq_err = CNT_W'(w_req) > r_count;
        w_n       = w_deq_err ? r_count[1:0] : w_req;

        w_free    = CNT_W'(DEPTH) - r_count;
        w_pop     = {1'b0, ex_br_valid[0]} + {1'b0, ex_br_valid[1]};
        w_enq_err = 1'b0;
        w_acc     = 2'd0;
        if (!rob_flush) begin
            w_enq_err = CNT_W'(w_pop) > w_free;
            w_acc     = w_enq_err ? w_free[1:0] : w_pop;
        end

        w_head_next  = r_head + IDX_W'(w_n);
        w_tail_next  = rob_flush ? w_head_next : r_tail + IDX_W'(w_acc);
        w_count_next = rob_flush ? CNT_W'(0)
                                 : r_count + CNT_W'(w_acc) - CNT_W'(w_n);

        w_v0 = w_n != 2'd0;
        w_v1 = w_n == 2'd2;
    end

    // Lane compaction: the oldest valid lane always lands in the tail slot
    always_comb begin
        w_lane0.npc    = ex_npc[`SEL(NPC_W, 0)];
        w_lane0.target = ex_target[`SEL(TGT_W, 0)];
        w_lane0.taken  = ex_taken[0];
        w_lane1.npc    = ex_npc[`SEL(NPC_W, 1)];
        w_lane1.target = ex_target[`SEL(TGT_W, 1)];
        w_lane1.taken  = ex_taken[1];
        w_wdata0       = ex_br_valid[0] ? w_lane0 : w_lane1;
    end

    br_update_queue_brq_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk        (clk),
        .i_we0      (w_acc != 2'd0),
        .i_waddr0   (r_tail),
        .i_wdata0   (w_wdata0),
        .i_we1      (w_acc == 2'd2),
        .i_waddr1   (r_tail + IDX_W'(1)),
        .i_wdata1   (w_lane1),
        .i_raddr0   (r_head),
        .i_raddr1   (r_head + IDX_W'(1)),
        .o_rdata0_c (w_rd0),
        .o_rdata1_c (w_rd1)
    );

    // Pointer/count state, sticky error and registered predictor update lanes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            ROB_br_en         <= '0;
            ROB_NPC           <= '0;
            ROB_taken         <= '0;
            ROB_taken_address <= '0;
            brq_ready         <= 1'b1;
            brq_err           <= 1'b0;
        end else begin
            r_head    <= w_head_next;
            r_tail    <= w_tail_next;
            r_count   <= w_count_next;
            brq_ready <= (CNT_W'(DEPTH) - w_count_next) >= CNT_W'(2);
            brq_err   <= brq_err | w_deq_err | w_enq_err;

            ROB_br_en                        <= {w_v1, w_v0};
            ROB_taken                        <= {w_v1 & w_rd1.taken, w_v0 & w_rd0.taken};
            ROB_NPC[`SEL(NPC_W, 0)]           <= w_v0 ? w_rd0.npc : '0;
            ROB_NPC[`SEL(NPC_W, 1)]           <= w_v1 ? w_rd1.npc : '0;
            ROB_taken_address[`SEL(TGT_W, 0)] <= w_v0 ? w_rd0.target : '0;
            ROB_taken_address[`SEL(TGT_W, 1)] <= w_v1 ? w_rd1.target : '0;
        end
    end

`ifdef BRQ_PERF_EN
    // Free-running retired and retired-taken branch counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_br_retired <= '0;
            perf_br_taken   <= '0;
        end else begin
            perf_br_retired <= perf_br_retired + 32'(w_n);
            perf_br_taken   <= perf_br_taken
                             + 32'(w_v0 & w_rd0.taken)
                             + 32'(w_v1 & w_rd1.taken);
        end
    end
`endif

endmodule
